// File: rtl/redmule_exp_packer_if.sv
// HWPE-style streaming interface: data beat with byte strobes and a valid/ready handshake.
interface hwpe_stream_intf_stream #(
   parameter int DATA_WIDTH = 512
) ();
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic [STRB_WIDTH-1:0] strb;

   modport source (output valid, output data, output strb, input ready);
   modport sink   (input valid, input data, input strb, output ready);
   modport master (output valid, output data, output strb, input ready);
   modport slave  (input valid, input data, input strb, output ready);
endinterface

// File: rtl/redmule_exp_packer.sv
// Packs shared exponents densely into BEAT_WIDTH-bit beats for write-back; a flush emits a
// partial beat whose byte strobes cover only the exponents actually collected.
module redmule_exp_packer #(
   parameter int EXP_WIDTH  = 8,
   parameter int BEAT_WIDTH = 512
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clear_i,
   input  logic [EXP_WIDTH-1:0]    exp_i,
   input  logic                    exp_valid_i,
   output logic                    exp_ready_o,
   input  logic                    flush_i,
   hwpe_stream_intf_stream.source  stream_o,
   output logic                    idle_o
);
   localparam int EXPS_PER_BEAT = BEAT_WIDTH / EXP_WIDTH;
   localparam int CNT_WIDTH     = $clog2(EXPS_PER_BEAT) + 1;
   localparam int STRB_WIDTH    = BEAT_WIDTH / 8;
   localparam int BYTES_PER_EXP = EXP_WIDTH / 8;
   localparam logic [CNT_WIDTH-1:0] LAST_SLOT = CNT_WIDTH'(EXPS_PER_BEAT - 1);

   function automatic logic [STRB_WIDTH-1:0] f_strb_mask(input logic [CNT_WIDTH-1:0] n);
      logic [STRB_WIDTH-1:0] m;
      m = '0;
      for (int b = 0; b < STRB_WIDTH; b++) begin
         if (b < int'(n) * BYTES_PER_EXP) begin
            m[b] = 1'b1;
         end else begin
            m[b] = 1'b0;
         end
      end
      return m;
   endfunction

   logic [BEAT_WIDTH-1:0] r_asm;
   logic [CNT_WIDTH-1:0]  r_slot;
   logic [BEAT_WIDTH-1:0] r_out_data;
   logic [STRB_WIDTH-1:0] r_out_strb;
   logic                  r_out_valid;
   logic                  r_flush_pend;

   logic                  w_out_free;
   logic                  w_last;
   logic                  w_accept;
   logic [BEAT_WIDTH-1:0] w_asm_next;
   logic [CNT_WIDTH-1:0]  w_n;
   logic                  w_flush;
   logic                  w_full;
   logic                  w_flush_xfer;
   logic                  w_load;

   assign w_out_free   = !r_out_valid || stream_o.ready;
   assign w_last       = (r_slot == LAST_SLOT);
   assign exp_ready_o  = !r_flush_pend && (!w_last || w_out_free);
   assign w_accept     = exp_valid_i && exp_ready_o;
   assign w_n          = r_slot + CNT_WIDTH'(w_accept);
   assign w_flush      = flush_i || r_flush_pend;
   assign w_full       = w_accept && w_last;
   // A same-cycle accept is packed before the flush closes the beat.
   assign w_flush_xfer = w_flush && !w_full && (w_n != '0) && w_out_free;
   assign w_load       = w_full || w_flush_xfer;

   // Assembly contents including the exponent accepted this cycle.
   always_comb begin
      w_asm_next = r_asm;
      if (w_accept) begin
         w_asm_next[int'(r_slot)*EXP_WIDTH +: EXP_WIDTH] = exp_i;
      end else begin
         w_asm_next = r_asm;
      end
   end

   // Assembly, slot counter, pending flush and output register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_asm        <= '0;
         r_slot       <= '0;
         r_out_data   <= '0;
         r_out_strb   <= '0;
         r_out_valid  <= 1'b0;
         r_flush_pend <= 1'b0;
      end else if (clear_i) begin
         r_asm        <= '0;
         r_slot       <= '0;
         r_out_data   <= '0;
         r_out_strb   <= '0;
         r_out_valid  <= 1'b0;
         r_flush_pend <= 1'b0;
      end else if (w_load) begin
         r_out_data   <= w_asm_next;
         r_out_strb   <= w_full ? {STRB_WIDTH{1'b1}} : f_strb_mask(w_n);
         r_out_valid  <= 1'b1;
         r_asm        <= '0;
         r_slot       <= '0;
         r_flush_pend <= 1'b0;
      end else begin
         if (r_out_valid && stream_o.ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_accept) begin
            r_asm  <= w_asm_next;
            r_slot <= r_slot + CNT_WIDTH'(1);
         end
         // Non-empty flush that could not transfer stays pending; empty one is dropped.
         if (w_flush) begin
            r_flush_pend <= (w_n != '0);
         end
      end
   end

   assign stream_o.valid = r_out_valid;
   assign stream_o.data  = r_out_data;
   assign stream_o.strb  = r_out_strb;
   assign idle_o         = (r_slot == '0) && !r_out_valid && !r_flush_pend;

endmodule

// File: tb/tb_redmule_exp_packer.sv
// Directed bench for redmule_exp_packer with 8-bit and 32-bit exponent instances and a beat scoreboard.
module tb_redmule_exp_packer;
   typedef struct packed {
      logic [511:0] d;
      logic [63:0]  s;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, clr8, v8, f8, r8o, idle8;
   logic [7:0]  e8;
   logic        clr32, v32, f32, r32o, idle32;
   logic [31:0] e32;

   hwpe_stream_intf_stream #(.DATA_WIDTH(512)) s8 ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(512)) s32 ();

   redmule_exp_packer #(.EXP_WIDTH(8), .BEAT_WIDTH(512)) u_dut8 (
      .clk_i(clk), .rst_i(rst), .clear_i(clr8), .exp_i(e8), .exp_valid_i(v8),
      .exp_ready_o(r8o), .flush_i(f8), .stream_o(s8), .idle_o(idle8));

   redmule_exp_packer #(.EXP_WIDTH(32), .BEAT_WIDTH(512)) u_dut32 (
      .clk_i(clk), .rst_i(rst), .clear_i(clr32), .exp_i(e32), .exp_valid_i(v32),
      .exp_ready_o(r32o), .flush_i(f32), .stream_o(s32), .idle_o(idle32));

   int n_vec = 0;
   int n_err = 0;
   beat_t q8[$];
   beat_t q32[$];
   logic [511:0] m8_data, m32_data;
   int m8_n, m32_n;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic add8(input logic [7:0] v);
      m8_data[m8_n*8 +: 8] = v;
      m8_n++;
      if (m8_n == 64) begin
         q8.push_back({m8_data, 64'hFFFF_FFFF_FFFF_FFFF});
         m8_data = '0;
         m8_n = 0;
      end
   endtask

   task automatic flush8(input logic [63:0] exp_strb);
      q8.push_back({m8_data, exp_strb});
      m8_data = '0;
      m8_n = 0;
   endtask

   task automatic add32(input logic [31:0] v);
      m32_data[m32_n*32 +: 32] = v;
      m32_n++;
      if (m32_n == 16) begin
         q32.push_back({m32_data, 64'hFFFF_FFFF_FFFF_FFFF});
         m32_data = '0;
         m32_n = 0;
      end
   endtask

   task automatic push8(input logic [7:0] v, input logic fl);
      bit ok;
      ok = 1'b0;
      e8 = v; v8 = 1'b1; f8 = fl;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (r8o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_err++;
         $display("FAIL push8_timeout: exponent %h never accepted", v);
      end
      @(posedge clk);
      #1;
      v8 = 1'b0; f8 = 1'b0;
      if (ok) add8(v);
   endtask

   task automatic push32(input logic [31:0] v, input logic fl);
      bit ok;
      ok = 1'b0;
      e32 = v; v32 = 1'b1; f32 = fl;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (r32o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_err++;
         $display("FAIL push32_timeout: exponent %h never accepted", v);
      end
      @(posedge clk);
      #1;
      v32 = 1'b0; f32 = 1'b0;
      if (ok) add32(v);
   endtask

   task automatic pulse8();
      f8 = 1'b1;
      @(posedge clk);
      #1;
      f8 = 1'b0;
   endtask

   // Scoreboard monitor: every transferred beat must match the oldest expected beat.
   initial begin
      beat_t b;
      forever begin
         @(negedge clk);
         if (!rst && s8.valid && s8.ready) begin
            n_vec++;
            if (q8.size() == 0) begin
               n_err++;
               $display("FAIL beat8_unexpected: got strb %h data %h, none expected", s8.strb, s8.data);
            end else begin
               b = q8.pop_front();
               if (s8.data !== b.d || s8.strb !== b.s) begin
                  n_err++;
                  $display("FAIL beat8: got strb %h data %h expected strb %h data %h", s8.strb, s8.data, b.s, b.d);
               end
            end
         end
         if (!rst && s32.valid && s32.ready) begin
            n_vec++;
            if (q32.size() == 0) begin
               n_err++;
               $display("FAIL beat32_unexpected: got strb %h data %h, none expected", s32.strb, s32.data);
            end else begin
               b = q32.pop_front();
               if (s32.data !== b.d || s32.strb !== b.s) begin
                  n_err++;
                  $display("FAIL beat32: got strb %h data %h expected strb %h data %h", s32.strb, s32.data, b.s, b.d);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [511:0] snap;
      rst = 1'b1; clr8 = 1'b0; clr32 = 1'b0;
      v8 = 1'b0; f8 = 1'b0; e8 = 8'h00;
      v32 = 1'b0; f32 = 1'b0; e32 = 32'h0;
      s8.ready = 1'b1; s32.ready = 1'b1;
      m8_data = '0; m8_n = 0; m32_data = '0; m32_n = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_valid", s8.valid, 1'b0);
      chk("rst_data", s8.data, '0);
      chk("rst_strb", s8.strb, '0);
      chk("rst_exp_ready", r8o, 1'b1);
      chk("rst_idle", idle8, 1'b1);
      @(posedge clk); #1;

      // Full beat 0x00..0x3F
      for (int i = 0; i < 64; i++) push8(8'(i), 1'b0);
      repeat (3) @(negedge clk);
      chk("full_idle", idle8, 1'b1);
      @(posedge clk); #1;

      // Backpressure: beat 1 stalls, slots 0..62 keep accepting, slot 63 blocks
      s8.ready = 1'b0;
      for (int i = 0; i < 127; i++) push8(8'(i), 1'b0);
      snap = q8[0].d;
      e8 = 8'h7F; v8 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_exp_ready", r8o, 1'b0);
         chk("stall_valid", s8.valid, 1'b1);
         chk("stall_data", s8.data, snap);
      end
      @(posedge clk); #1;
      s8.ready = 1'b1;
      @(negedge clk);
      chk("stall_release_ready", r8o, 1'b1);
      @(posedge clk); #1;
      v8 = 1'b0;
      add8(8'h7F);
      repeat (3) @(posedge clk); #1;

      // Partial flush of 5, then a redundant flush
      for (int i = 0; i < 5; i++) push8(8'hA0 + 8'(i), 1'b0);
      pulse8();
      flush8(64'h0000_0000_0000_001F);
      repeat (2) @(posedge clk); #1;
      pulse8();
      repeat (3) @(negedge clk);
      chk("double_flush_idle", idle8, 1'b1);
      @(posedge clk); #1;

      // Same-cycle flush, then a flush that must pend behind a stalled output
      s8.ready = 1'b0;
      push8(8'hB0, 1'b0);
      push8(8'hB1, 1'b0);
      push8(8'hB2, 1'b1);
      flush8(64'h0000_0000_0000_0007);
      push8(8'hC0, 1'b0);
      push8(8'hC1, 1'b0);
      push8(8'hC2, 1'b1);
      flush8(64'h0000_0000_0000_0007);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("pend_exp_ready", r8o, 1'b0);
         chk("pend_idle", idle8, 1'b0);
      end
      @(posedge clk); #1;
      pulse8();
      @(negedge clk);
      chk("merged_exp_ready", r8o, 1'b0);
      @(posedge clk); #1;
      s8.ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("pend_done_ready", r8o, 1'b1);
      chk("pend_done_idle", idle8, 1'b1);
      @(posedge clk); #1;

      // W configuration: one full beat then three lanes flushed
      for (int i = 0; i < 16; i++) push32(32'h1000_0000 + 32'(i), 1'b0);
      push32(32'hDEAD_0001, 1'b0);
      push32(32'hDEAD_0002, 1'b0);
      push32(32'hDEAD_0003, 1'b1);
      q32.push_back({m32_data, 64'h0000_0000_0000_0FFF});
      m32_data = '0; m32_n = 0;
      repeat (3) @(negedge clk);
      chk("w_idle", idle32, 1'b1);
      @(posedge clk); #1;

      // Asynchronous reset mid-operation with a stalled beat and 30 partial exponents
      s8.ready = 1'b0;
      for (int i = 0; i < 94; i++) push8(8'h20 + 8'(i), 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", s8.valid, 1'b0);
      chk("arst_strb", s8.strb, '0);
      chk("arst_exp_ready", r8o, 1'b1);
      chk("arst_idle", idle8, 1'b1);
      q8.delete(); m8_data = '0; m8_n = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      s8.ready = 1'b1;
      repeat (70) @(posedge clk); #1;

      // Soft clear mid-operation, then a clean partial beat
      s8.ready = 1'b0;
      for (int i = 0; i < 94; i++) push8(8'h40 + 8'(i), 1'b0);
      clr8 = 1'b1;
      @(posedge clk); #1;
      clr8 = 1'b0;
      chk("clr_valid", s8.valid, 1'b0);
      chk("clr_data", s8.data, '0);
      chk("clr_exp_ready", r8o, 1'b1);
      chk("clr_idle", idle8, 1'b1);
      q8.delete(); m8_data = '0; m8_n = 0;
      s8.ready = 1'b1;
      repeat (70) @(posedge clk); #1;
      push8(8'hD0, 1'b0);
      push8(8'hD1, 1'b1);
      flush8(64'h0000_0000_0000_0003);
      repeat (5) @(negedge clk);

      chk("q8_drained", 512'(q8.size()), '0);
      chk("q32_drained", 512'(q32.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/redmule_exp_packer.md
# redmule_exp_packer

Packs individual shared exponents produced by the RedMulE output path into compact 512-bit beats and emits them on an HWPE stream toward the streamer sink for memory write-back. It is the transmit-side counterpart of the exponent prefetch buffer: lane `i` of each beat carries the `i`-th exponent accepted, with no padding between exponents. A flush command closes a partial beat with byte strobes so tail exponents reach memory without overwriting neighbours.

## Interface
**Parameters**
- `EXP_WIDTH`, default 8: width of one exponent. Use 8 for X/Z, 32 for W vectors. Must be a multiple of 8 and divide `BEAT_WIDTH`.
- `BEAT_WIDTH`, default 512: width of the output beat.
- `EXPS_PER_BEAT` (localparam) = `BEAT_WIDTH/EXP_WIDTH`.
- `CNT_WIDTH` (localparam) = `$clog2(EXPS_PER_BEAT)+1`.

**Ports**
- `clk_i`, input, 1: single clock, rising edge.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `clear_i`, input, 1: synchronous soft clear. Returns all state to reset values.
- `exp_i`, input, `EXP_WIDTH`: exponent to pack.
- `exp_valid_i`, input, 1: `exp_i` valid.
- `exp_ready_o`, output, 1: packer accepts `exp_i` this cycle.
- `flush_i`, input, 1: single-cycle pulse that closes the current partial beat.
- `stream_o`, `hwpe_stream_intf_stream.source`, `BEAT_WIDTH`: carries `data`, `strb` (`BEAT_WIDTH/8`), `valid` and `ready`.
- `idle_o`, output, 1: assembly empty, output register empty, no flush pending.

## Operation
**Storage**
- Assembly register `asm_q` (`BEAT_WIDTH`).
- Slot counter `slot_q` (`CNT_WIDTH`, range 0..`EXPS_PER_BEAT`-1).
- Output register `out_data_q`, `out_strb_q`, `out_valid_q`.
- Flag `flush_pend_q`.

**Accepting exponents**
- An exponent is accepted when `exp_valid_i && exp_ready_o`.
- On accept, `exp_i` is written to `asm_q[slot_q*EXP_WIDTH +: EXP_WIDTH]`.
- `out_free` = `!out_valid_q || stream_o.ready`.
- `exp_ready_o` = `!flush_pend_q && (slot_q != EXPS_PER_BEAT-1 || out_free)`. This is combinational on `stream_o.ready`.

**Completing a beat**
- If an accept hits slot `EXPS_PER_BEAT-1`:
  - the full beat (including `exp_i`) moves to the output register;
  - `out_strb_q` is all ones;
  - `slot_q` returns to 0;
  - `asm_q` is zeroed.
- Otherwise `slot_q` increments by 1.

**Flush**
- A flush is captured when `flush_i` is high, or `flush_pend_q` is set.
- The effective count `n` = `slot_q` plus 1 if an exponent is accepted in the same cycle. That exponent is packed first.
- If `n == 0`: the flush is a no-op and `flush_pend_q` clears.
- If `n == EXPS_PER_BEAT`: the beat completes normally and the flush is consumed.
- Otherwise, if `out_free`:
  - the partial beat goes to the output register;
  - lanes ≥ `n` are zero;
  - `out_strb_q` has the low `n*EXP_WIDTH/8` bits set;
  - `slot_q` and `asm_q` clear;
  - `flush_pend_q` clears.
- Otherwise `flush_pend_q` sets and stays set until the transfer happens. `exp_ready_o` is 0 while it is set.

**Output and control**
- `out_valid_q` clears on `stream_o.valid && stream_o.ready` unless a new beat loads in the same cycle. In that case it stays 1 with the new data.
- `clear_i` (when `rst_i` is low) discards any partial or pending beat.
- Reset mid-beat discards all contents. No beat is emitted.

## Timing
**Reset values**
- `stream_o.valid` = 0, `stream_o.data` = 0, `stream_o.strb` = 0.
- `exp_ready_o` = 1, `idle_o` = 1.
- `slot_q` = 0, `flush_pend_q` = 0, `asm_q` = 0.

**Latency and throughput**
- A beat-completing accept or a flush transfer in cycle N gives `stream_o.valid` = 1 in cycle N+1.
- With `stream_o.ready` held high, sustained throughput is 1 exponent per cycle, with no bubble at the beat boundary.

**Handshake rules**
- While `stream_o.valid && !stream_o.ready`, `data` and `strb` hold stable and `valid` does not drop.
- `stream_o.valid` never depends combinationally on `stream_o.ready`.

**Boundary conditions**
- Beat boundary with the output register full and not draining: `exp_ready_o` = 0 only at slot `EXPS_PER_BEAT-1`. Slots below that keep accepting.
- Back-to-back `flush_i` pulses with nothing new accepted in between: the second is a no-op.
- `flush_i` while `flush_pend_q` is already set: merged into the pending flush.
- `idle_o` = `slot_q == 0 && !out_valid_q && !flush_pend_q`. It is registered-state only.

## Test plan
- **Full beat:** `EXP_WIDTH=8`; send exponents 0x00..0x3F back-to-back with ready=1. Expect one beat one cycle after the 64th accept, with byte `i` = `i` and `strb` = all ones. Then `idle_o` = 1.
- **Sustained stream with backpressure:** send 128 exponents and hold ready=0 for 10 cycles after the first beat. Expect `exp_ready_o` = 0 at slot 63 only. Beat 1 data is stable during the stall. Beat 2 = 0x40..0x7F, with no loss or duplication.
- **Partial flush:** accept 5 exponents 0xA0..0xA4, then pulse `flush_i`. Expect a beat with bytes 0..4 = 0xA0..0xA4, bytes 5..63 = 0, and `strb` = 0x1F.
- **Same-cycle flush:** pulse `flush_i` in the same cycle as the 3rd accept. Expect `strb` = 0x07. With the output register stalled, expect `flush_pend_q` = 1 and `exp_ready_o` = 0 until ready rises.
- **W configuration:** `EXP_WIDTH=32`; send 16 vectors, then 3 vectors plus a flush. Expect a full beat, then a beat with `strb` = 0xFFF and lanes 3..15 = 0.
- **Reset and clear mid-operation:**
  - Assert `rst_i` asynchronously after 30 exponents. Outputs go to reset values immediately, and no beat is emitted afterwards.
  - Repeat with `clear_i`. Same result on the next edge.
